relay_tx_framer: RTL and testbench
==================================

RELAY_TX_FRAMER -- requirements
Module: relay_tx_framer

Interface
REQ-001 SHALL have port ck_1356meg, input, 1 bit: 13.56 MHz clock; all sequential logic on its rising edge.
REQ-002 SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port mode, input, 3 bits: simulate mode; 3'b101 = FAKE_READER framing, 3'b110 = FAKE_TAG framing, any other value = disabled.
REQ-004 SHALL have port byte_in, input, 8 bits: payload byte, sent MSB first.
REQ-005 SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-006 SHALL have port byte_last, input, 1 bit: qualifies byte_in as the final byte of the frame.
REQ-007 SHALL have port byte_ready, output, 1 bit: the byte is consumed this cycle.
REQ-008 SHALL have port data_out, output, 1 bit: serial relay line, bit-rate 847.5 kHz.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port underrun, output, 1 bit: sticky flag; the frame was terminated by payload starvation.

Function
REQ-011 SHALL contain a free-running 4-bit divider; bit_tick is the cycle in which the divider equals 4'd15, giving one bit period per 16 clocks.
REQ-012 SHALL update data_out, state and bit counters only on bit_tick; data_out is registered and held for 16 clocks per bit.
REQ-013 SHALL implement these states: IDLE, PREAMBLE, START, DATA, END.
REQ-014 IDLE: data_out=0 and busy=0; on a bit_tick with byte_valid=1 and mode in {101,110}, latch mode into fmode, clear underrun and enter PREAMBLE.
REQ-015 PREAMBLE: emit 16 zero bits, then enter START.
REQ-016 START: emit 8'hC0 if fmode=101, or 8'hF0 if fmode=110, MSB first, then enter DATA.
REQ-017 byte_ready SHALL be combinational and asserted only on the bit_tick at which the next payload byte is needed: the last START bit tick, or the last bit tick of a non-final DATA byte.
REQ-018 A transfer occurs when byte_ready=1 and byte_valid=1 in the same cycle; byte_in and byte_last are then latched into the shift register.
REQ-019 The first payload bit SHALL appear on data_out at the bit_tick that follows the transfer.
REQ-020 If byte_ready=1 and byte_valid=0, the block SHALL set underrun=1 and enter END without emitting a payload byte.
REQ-021 After a byte latched with byte_last=1 completes, the block SHALL enter END; byte_ready stays low at that byte boundary.
REQ-022 END: emit 16 zero bits if fmode=101, or 8 zero bits if fmode=110, then return to IDLE.
REQ-023 busy SHALL be 1 in PREAMBLE, START, DATA and END.
REQ-024 Total frame length in bits SHALL be 40+8N for reader framing and 32+8N for tag framing, where N is the number of bytes transferred.
REQ-025 If mode leaves {101,110} while busy, the block SHALL go to IDLE on the next clock (not the next bit_tick); data_out=0, busy=0, and no byte_ready is issued.
REQ-026 Changes of mode between 101 and 110 mid-frame SHALL be ignored; fmode governs the frame until END completes.
REQ-027 Payload bytes equal to 8'h00 are transmitted unmodified; end-marker aliasing is the sender's responsibility.
REQ-028 The divider and bit counters SHALL wrap modulo their widths with no overflow side effects.

Reset
REQ-029 While nrst=0, the block SHALL hold: state=IDLE, divider=0, data_out=0, busy=0, underrun=0, shift register=0, fmode=0; byte_ready is 0.
REQ-030 Assertion of nrst mid-frame SHALL abort the frame immediately, with no END marker emitted.
REQ-031 After nrst deasserts, the first bit_tick SHALL occur on the 16th rising clock edge.

Verification
REQ-032 mode=101, one byte 8'hA5 with byte_last=1 held valid -> data_out over 48 bit periods = 16x0, C0, A5, 16x0; byte_ready pulses exactly once; underrun=0.
REQ-033 mode=110, bytes 8'h12 then 8'h34 (byte_last=1 on the second) -> 48 bits = 16x0, F0, 12, 34, 8x0; busy high for exactly 768 clocks.
REQ-034 mode=101, byte_valid dropped after the first byte 8'hFF (byte_last=0) -> 16x0, C0, FF, 16x0; underrun=1 until the next frame start.
REQ-035 mode switched from 101 to 000 during DATA -> data_out=0 and busy=0 one clock later; no further byte_ready pulses.
REQ-036 nrst pulsed low during START -> all outputs 0 asynchronously; after release, a new frame starts with a full 16-bit preamble.
REQ-037 mode=011 with byte_valid=1 -> no activity for 100 bit periods: busy=0, byte_ready=0, data_out=0.

Source files
------------

// File: rtl/relay_tx_framer.sv
// relay_tx_framer
//   Serialises a payload byte stream into a relay frame on a 1-bit line at
//   one bit per 16 clocks (13.56 MHz / 16 = 847.5 kHz).
//   Frame = 16-bit zero preamble, start pattern (C0 reader / F0 tag),
//   N payload bytes MSB first, zero end marker (16 bits reader / 8 bits tag).
//
// Ports
//   ck_1356meg  in   13.56 MHz clock, rising edge
//   nrst        in   asynchronous active-low reset
//   mode[2:0]   in   3'b101 reader framing, 3'b110 tag framing, else disabled
//   byte_in[7:0] in  payload byte
//   byte_valid  in   byte_in / byte_last are valid
//   byte_last   in   byte_in is the final byte of the frame
//   byte_ready  out  combinational, high only in the bit_tick cycle where the
//                    next payload byte is needed
//   data_out    out  registered serial line
//   busy        out  a frame is in progress
//   underrun    out  sticky: frame was ended by payload starvation
//   dbg_state   out  current FSM state (for observation only)
//
// Handshake: a byte is transferred in the cycle where byte_ready and
// byte_valid are both 1. byte_ready does not depend on byte_valid and is
// only ever offered for a single clock; if byte_valid is low in that clock
// the frame is closed with an end marker and underrun is set.

module relay_tx_framer (
  input  logic       ck_1356meg,
  input  logic       nrst,
  input  logic [2:0] mode,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       data_out,
  output logic       busy,
  output logic       underrun,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_START    = 3'd2,
    S_DATA     = 3'd3,
    S_END      = 3'd4
  } state_t;

  state_t     r_state;
  logic [3:0] r_div;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_last;
  logic [2:0] r_fmode;
  logic       r_data_out;
  logic       r_underrun;

  state_t     w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic [7:0] w_shift_nxt;
  logic       w_last_nxt;
  logic [2:0] w_fmode_nxt;
  logic       w_data_nxt;
  logic       w_underrun_nxt;
  logic       w_byte_ready;

  logic       w_tick;
  logic       w_mode_ok;
  logic       w_reader;
  logic [7:0] w_start_pat;
  logic [3:0] w_end_last;

  assign w_tick      = (r_div == 4'd15);
  assign w_mode_ok   = (mode == 3'b101) || (mode == 3'b110);
  assign w_reader    = (r_fmode == 3'b101);
  assign w_start_pat = w_reader ? 8'hC0 : 8'hF0;
  assign w_end_last  = w_reader ? 4'd15 : 4'd7;

  // Free-running divider; wraps 15 -> 0.
  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) r_div <= 4'd0;
    else       r_div <= r_div + 4'd1;
  end

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_shift    <= 8'd0;
      r_last     <= 1'b0;
      r_fmode    <= 3'd0;
      r_data_out <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_last     <= w_last_nxt;
      r_fmode    <= w_fmode_nxt;
      r_data_out <= w_data_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  // Each bit_tick emits the next bit: a tick inside a state either advances
  // within it or, on its last bit, moves on and emits the first bit of the
  // following state, so the line never has a gap between fields.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_last_nxt     = r_last;
    w_fmode_nxt    = r_fmode;
    w_data_nxt     = r_data_out;
    w_underrun_nxt = r_underrun;
    w_byte_ready   = 1'b0;

    if ((r_state != S_IDLE) && !w_mode_ok) begin
      // Mode withdrawn: drop the frame on this clock, no end marker.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 4'd0;
      w_data_nxt  = 1'b0;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          w_data_nxt = 1'b0;
          if (byte_valid && w_mode_ok) begin
            w_fmode_nxt    = mode;
            w_underrun_nxt = 1'b0;
            w_last_nxt     = 1'b0;
            w_state_nxt    = S_PREAMBLE;
            w_cnt_nxt      = 4'd0;
          end
        end
        S_PREAMBLE: begin
          if (r_cnt == 4'd15) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = 4'd0;
            w_data_nxt  = w_start_pat[7];
            w_shift_nxt = {w_start_pat[6:0], 1'b0};
          end else begin
            w_cnt_nxt  = r_cnt + 4'd1;
            w_data_nxt = 1'b0;
          end
        end
        S_START, S_DATA: begin
          if (r_cnt != 4'd7) begin
            w_cnt_nxt   = r_cnt + 4'd1;
            w_data_nxt  = r_shift[7];
            w_shift_nxt = {r_shift[6:0], 1'b0};
          end else if ((r_state == S_DATA) && r_last) begin
            w_state_nxt = S_END;
            w_cnt_nxt   = 4'd0;
            w_data_nxt  = 1'b0;
          end else begin
            w_byte_ready = 1'b1;
            w_cnt_nxt    = 4'd0;
            if (byte_valid) begin
              w_state_nxt = S_DATA;
              w_data_nxt  = byte_in[7];
              w_shift_nxt = {byte_in[6:0], 1'b0};
              w_last_nxt  = byte_last;
            end else begin
              w_state_nxt    = S_END;
              w_data_nxt     = 1'b0;
              w_underrun_nxt = 1'b1;
            end
          end
        end
        S_END: begin
          w_data_nxt = 1'b0;
          if (r_cnt == w_end_last) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
          w_data_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = w_byte_ready;
  assign data_out   = r_data_out;
  assign busy       = (r_state != S_IDLE);
  assign underrun   = r_underrun;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_relay_tx_framer.sv
module tb_relay_tx_framer;

  logic       ck_1356meg;
  logic       nrst;
  logic [2:0] mode;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic       data_out;
  logic       busy;
  logic       underrun;
  logic [2:0] dbg_state;

  int n_vec;
  int n_fail;

  relay_tx_framer dut (
    .ck_1356meg (ck_1356meg),
    .nrst       (nrst),
    .mode       (mode),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .data_out   (data_out),
    .busy       (busy),
    .underrun   (underrun),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial ck_1356meg = 1'b0;
  always #5 ck_1356meg = ~ck_1356meg;

  // ---------------- driver / capture tasks ----------------
  // Presents n bytes (b0 then b1); byte_last only on the final one when
  // last_final is set. drop removes byte_valid after the final transfer.
  task automatic feed(input logic [7:0] b0, input logic [7:0] b1, input int n,
                      input bit last_final, input bit drop, output bit to);
    bit got;
    to = 1'b0;
    for (int i = 0; i < n; i++) begin
      byte_in    = (i == 0) ? b0 : b1;
      byte_last  = (i == n - 1) ? last_final : 1'b0;
      byte_valid = 1'b1;
      got = 1'b0;
      for (int j = 0; j < 3000; j++) begin
        @(negedge ck_1356meg);
        if (byte_ready === 1'b1 && byte_valid === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        to = 1'b1;
        return;
      end
      @(posedge ck_1356meg);
      #1;
    end
    if (drop) byte_valid = 1'b0;
  endtask

  // Waits for busy, then samples data_out mid-bit every 16 clocks until busy
  // falls. Also counts busy clocks and byte_ready cycles.
  task automatic capture_frame(output logic [63:0] bits, output int nbits,
                               output int rdy, output int bclk,
                               output int wcnt, output bit to);
    bits = 64'd0; nbits = 0; rdy = 0; bclk = 0; wcnt = 0; to = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge ck_1356meg);
      if (busy === 1'b1) begin
        wcnt = i;
        break;
      end
    end
    if (wcnt == 0) begin
      to = 1'b1;
      return;
    end
    for (int k = 0; k < 2000; k++) begin
      if (k > 0) @(negedge ck_1356meg);
      if (busy !== 1'b1) break;
      bclk++;
      if (k % 16 == 0) begin
        bits = {bits[62:0], data_out};
        nbits++;
      end
      if (byte_ready === 1'b1) rdy++;
      if (k == 1999) to = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    nrst = 1'b0; mode = 3'b000; byte_in = 8'h00; byte_valid = 1'b0; byte_last = 1'b0;
    repeat (3) @(negedge ck_1356meg);
    n_vec++;
    if ({busy, data_out, byte_ready, underrun} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy/data/ready/underrun=%b expected 0000",
               {busy, data_out, byte_ready, underrun});
    end
    n_vec++;
    if (dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    nrst = 1'b1;
    repeat (4) @(negedge ck_1356meg);
  endtask

  task automatic test_reader_one_byte;
    logic [63:0] bits; int nb, rdy, bclk, wc; bit to_f, to_c;
    mode = 3'b101;
    fork
      feed(8'hA5, 8'h00, 1, 1'b1, 1'b0, to_f);
      capture_frame(bits, nb, rdy, bclk, wc, to_c);
    join
    byte_valid = 1'b0;
    n_vec++;
    if (to_f || to_c) begin
      n_fail++;
      $display("FAIL rd1_timeout: feed=%0b capture=%0b expected 0/0", to_f, to_c);
    end
    n_vec++;
    if (bits !== 64'h0000_0000_C0A5_0000) begin
      n_fail++;
      $display("FAIL rd1_bits: got %h expected 0000_0000_c0a5_0000", bits);
    end
    n_vec++;
    if (nb != 48) begin
      n_fail++;
      $display("FAIL rd1_len: got %0d bits expected 48", nb);
    end
    n_vec++;
    if (rdy != 1) begin
      n_fail++;
      $display("FAIL rd1_ready_pulses: got %0d expected 1", rdy);
    end
    n_vec++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rd1_underrun: got %b expected 0", underrun);
    end
  endtask

  task automatic test_underrun;
    logic [63:0] bits; int nb, rdy, bclk, wc; bit to_f, to_c;
    mode = 3'b101;
    fork
      feed(8'hFF, 8'h00, 1, 1'b0, 1'b1, to_f);
      capture_frame(bits, nb, rdy, bclk, wc, to_c);
    join
    byte_valid = 1'b0;
    n_vec++;
    if (to_f || to_c) begin
      n_fail++;
      $display("FAIL ur_timeout: feed=%0b capture=%0b expected 0/0", to_f, to_c);
    end
    n_vec++;
    if (bits !== 64'h0000_0000_C0FF_0000 || nb != 48) begin
      n_fail++;
      $display("FAIL ur_bits: got %h (%0d bits) expected 0000_0000_c0ff_0000 (48)", bits, nb);
    end
    n_vec++;
    if (rdy != 2) begin
      n_fail++;
      $display("FAIL ur_ready_pulses: got %0d expected 2", rdy);
    end
    n_vec++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ur_flag: got %b expected 1", underrun);
    end
    repeat (40) @(negedge ck_1356meg);
    n_vec++;
    if (underrun !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ur_sticky: got underrun=%b busy=%b expected 1/0", underrun, busy);
    end
  endtask

  task automatic test_tag_two_bytes;
    logic [63:0] bits; int nb, rdy, bclk, wc; bit to_f, to_c;
    mode = 3'b110;
    fork
      feed(8'h12, 8'h34, 2, 1'b1, 1'b0, to_f);
      capture_frame(bits, nb, rdy, bclk, wc, to_c);
    join
    byte_valid = 1'b0;
    n_vec++;
    if (to_f || to_c) begin
      n_fail++;
      $display("FAIL tag_timeout: feed=%0b capture=%0b expected 0/0", to_f, to_c);
    end
    n_vec++;
    if (bits !== 64'h0000_0000_F012_3400 || nb != 48) begin
      n_fail++;
      $display("FAIL tag_bits: got %h (%0d bits) expected 0000_0000_f012_3400 (48)", bits, nb);
    end
    n_vec++;
    if (bclk != 768) begin
      n_fail++;
      $display("FAIL tag_busy_clocks: got %0d expected 768", bclk);
    end
    n_vec++;
    if (rdy != 2) begin
      n_fail++;
      $display("FAIL tag_ready_pulses: got %0d expected 2", rdy);
    end
    n_vec++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL tag_underrun_cleared: got %b expected 0", underrun);
    end
  endtask

  task automatic test_mode_abort;
    int w; int rdy_seen; int busy_seen;
    mode = 3'b101; byte_in = 8'hFF; byte_last = 1'b0; byte_valid = 1'b1;
    w = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge ck_1356meg);
      if (busy === 1'b1) begin w = i; break; end
    end
    // 24 bit periods in = 40 clocks into the payload byte (all ones).
    repeat (24 * 16 + 40) @(negedge ck_1356meg);
    n_vec++;
    if (w == 0 || busy !== 1'b1 || data_out !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got busy=%b data=%b start_wait=%0d expected 1/1 >0", busy, data_out, w);
    end
    @(posedge ck_1356meg); #1;
    mode = 3'b000;
    @(negedge ck_1356meg);
    n_vec++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_same_clock: got busy=%b expected 1", busy);
    end
    @(negedge ck_1356meg);
    n_vec++;
    if (busy !== 1'b0 || data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next_clock: got busy=%b data=%b expected 0/0", busy, data_out);
    end
    rdy_seen = 0; busy_seen = 0;
    repeat (64) begin
      @(negedge ck_1356meg);
      if (byte_ready !== 1'b0) rdy_seen++;
      if (busy !== 1'b0) busy_seen++;
    end
    n_vec++;
    if (rdy_seen != 0 || busy_seen != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got ready_cycles=%0d busy_cycles=%0d expected 0/0", rdy_seen, busy_seen);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] bits; int nb, rdy, bclk, wc, w; bit to_c;
    mode = 3'b101; byte_in = 8'h77; byte_last = 1'b1; byte_valid = 1'b1;
    w = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge ck_1356meg);
      if (busy === 1'b1) begin w = i; break; end
    end
    // 270 clocks in: first START bit (C0 bit 7 = 1).
    repeat (270) @(negedge ck_1356meg);
    n_vec++;
    if (w == 0 || busy !== 1'b1 || data_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got busy=%b data=%b start_wait=%0d expected 1/1 >0", busy, data_out, w);
    end
    nrst = 1'b0;
    #1;
    n_vec++;
    if ({busy, data_out, byte_ready, underrun} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_async: got busy/data/ready/underrun=%b expected 0000",
               {busy, data_out, byte_ready, underrun});
    end
    repeat (5) @(negedge ck_1356meg);
    byte_in = 8'h5A;
    n_vec++;
    if ({busy, data_out, byte_ready, underrun} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_hold: got busy/data/ready/underrun=%b expected 0000",
               {busy, data_out, byte_ready, underrun});
    end
    nrst = 1'b1;
    capture_frame(bits, nb, rdy, bclk, wc, to_c);
    byte_valid = 1'b0;
    n_vec++;
    if (to_c || wc != 16) begin
      n_fail++;
      $display("FAIL rst_first_tick: got start after %0d clocks (timeout=%0b) expected 16", wc, to_c);
    end
    n_vec++;
    if (bits !== 64'h0000_0000_C05A_0000 || nb != 48) begin
      n_fail++;
      $display("FAIL rst_new_frame: got %h (%0d bits) expected 0000_0000_c05a_0000 (48)", bits, nb);
    end
  endtask

  task automatic test_disabled_mode;
    int act;
    mode = 3'b011; byte_in = 8'h81; byte_last = 1'b1; byte_valid = 1'b1;
    act = 0;
    repeat (100 * 16) begin
      @(negedge ck_1356meg);
      if (busy !== 1'b0 || byte_ready !== 1'b0 || data_out !== 1'b0) act++;
    end
    n_vec++;
    if (act != 0) begin
      n_fail++;
      $display("FAIL disabled_quiet: got %0d active clocks expected 0", act);
    end
    byte_valid = 1'b0;
    mode = 3'b000;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_vec = 0;
    n_fail = 0;
    test_reset();
    test_reader_one_byte();
    repeat (40) @(negedge ck_1356meg);
    test_underrun();
    test_tag_two_bytes();
    repeat (40) @(negedge ck_1356meg);
    test_mode_abort();
    repeat (40) @(negedge ck_1356meg);
    test_reset_mid_frame();
    repeat (40) @(negedge ck_1356meg);
    test_disabled_mode();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
